// File: rtl/cam_rx_page_mgr.sv
// cam_rx_page_mgr
//    Page-buffer controller between the camera byte stream and the rx RAM
//    read by the CSR block. Frames are cut into pages of pkt_size+1 bytes in
//    a ring of PAGE_NUM = 1<<PAGE_W pages held in an external 1R1W RAM.
//    Committed pages are handed to the CSR reader in order and freed on
//    rx_ram_rd_done. When the ring is full the frame is dropped and one
//    rx_ram_lost pulse is raised.
//
//    Optional feature macro: CAM_RX_FRAME_SEQ_EN -- 6-bit frame sequence
//    number stored in flags[5:0] of every page of a frame (0 when undefined).
//
// Ports
//    clk, reset_n                 clock, async active-low reset
//    pkt_size                     page size - 1, sampled when a page opens
//    wr_valid/data/sof/eof        camera byte stream, no backpressure
//    ram_wr_en/addr/data          RAM write port, addr = {page, byte index}
//    ram_rd_addr, ram_rd_data     RAM read port, addr = {rd_ptr, rx_ram_rd_addr}
//    rx_ram_rd_addr               CSR byte index within the head page
//    rx_ram_rd_done               free the head page
//    rx_clean_all                 flush the ring and drop any partial frame
//    rx_ram_rd_byte               read data to the CSR block
//    rx_ram_rd_flags              {last idx, sof, eof, seq} of head page
//    rx_ram_lost                  one pulse per dropped frame
//    rx_pending                   at least one committed page
//
// state  | meaning
// W_IDLE | between frames, waiting for sof
// W_FILL | page open, writing bytes at idx
// W_DROP | discarding the rest of a frame

module cam_rx_page_mgr #(
   parameter int PAGE_W = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          pkt_size,
   input  logic                wr_valid,
   input  logic [7:0]          wr_data,
   input  logic                wr_sof,
   input  logic                wr_eof,
   output logic                ram_wr_en,
   output logic [PAGE_W+7:0]   ram_wr_addr,
   output logic [7:0]          ram_wr_data,
   output logic [PAGE_W+7:0]   ram_rd_addr,
   input  logic [7:0]          ram_rd_data,
   input  logic [7:0]          rx_ram_rd_addr,
   input  logic                rx_ram_rd_done,
   input  logic                rx_clean_all,
   output logic [7:0]          rx_ram_rd_byte,
   output logic [15:0]         rx_ram_rd_flags,
   output logic                rx_ram_lost,
   output logic                rx_pending
);

   localparam int PAGE_NUM = 1 << PAGE_W;
   localparam int CNT_W    = PAGE_W + 1;
   localparam int SUM_W    = PAGE_W + 2;

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;

   w_state_t            state, state_n;
   logic [PAGE_W-1:0]   wr_ptr, rd_ptr, wr_pg;
   logic [CNT_W-1:0]    count;
   logic [7:0]          idx, idx_n, size_q, wr_idx;
   logic                page_sof;
   logic [15:0]         flags_q [PAGE_NUM];
   logic                lost_q, lost_n;
   logic                rd_ok, commit_a, commit_b, start_req, start_ok;
   logic                need_next, next_open, wr_en_c;
   logic [15:0]         flags_a, flags_b;
   logic [SUM_W-1:0]    cnt_rd;
   logic [5:0]          seq_now, seq_cur;

`ifdef CAM_RX_FRAME_SEQ_EN
   logic [5:0] seq_cnt, fseq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_cnt <= '0;
         fseq_q  <= '0;
      end else if (start_ok && !rx_clean_all) begin
         fseq_q  <= seq_cnt;
         seq_cnt <= seq_cnt + 6'd1;
      end
   end

   assign seq_now = seq_cnt;
   assign seq_cur = fseq_q;
`else
   assign seq_now = '0;
   assign seq_cur = '0;
`endif

   assign rd_ok  = rx_ram_rd_done && (count != '0);
   // A page freed in this clock is already available to the writer.
   assign cnt_rd = SUM_W'(count) - SUM_W'(rd_ok);

   // commit_a closes the page at wr_ptr; commit_b closes a page opened in
   // this same clock (single-byte page), which sits at wr_ptr + commit_a.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      commit_a  = 1'b0;
      commit_b  = 1'b0;
      flags_a   = '0;
      flags_b   = '0;
      wr_en_c   = 1'b0;
      wr_pg     = wr_ptr;
      wr_idx    = idx;
      start_req = 1'b0;
      start_ok  = 1'b0;
      need_next = 1'b0;
      next_open = 1'b0;
      lost_n    = 1'b0;
      if (wr_valid) begin
         unique case (state)
            W_IDLE: start_req = wr_sof;
            W_FILL: begin
               if (wr_sof) begin
                  // An empty continuation page is simply reused.
                  if (idx != 8'd0) begin
                     commit_a = 1'b1;
                     flags_a  = {idx - 8'd1, page_sof, 1'b0, seq_cur};
                  end
                  start_req = 1'b1;
               end else begin
                  wr_en_c = 1'b1;
                  if (wr_eof || idx == size_q) begin
                     commit_a = 1'b1;
                     flags_a  = {idx, page_sof, wr_eof, seq_cur};
                     if (wr_eof) state_n = W_IDLE;
                     else        need_next = 1'b1;
                  end else begin
                     idx_n = idx + 8'd1;
                  end
               end
            end
            W_DROP: begin
               if (wr_sof)      start_req = 1'b1;
               else if (wr_eof) state_n = W_IDLE;
            end
            default: state_n = W_IDLE;
         endcase

         if (start_req) begin
            if (cnt_rd + SUM_W'(commit_a) < SUM_W'(PAGE_NUM)) begin
               start_ok = 1'b1;
               wr_en_c  = 1'b1;
               wr_pg    = wr_ptr + PAGE_W'(commit_a);
               wr_idx   = 8'd0;
               state_n  = W_FILL;
               idx_n    = 8'd1;
               if (wr_eof || pkt_size == 8'd0) begin
                  commit_b = 1'b1;
                  flags_b  = {8'd0, 1'b1, wr_eof, seq_now};
                  if (wr_eof) state_n = W_IDLE;
                  else        need_next = 1'b1;
               end
            end else begin
               lost_n  = 1'b1;
               state_n = wr_eof ? W_IDLE : W_DROP;
            end
         end

         // Frame continues past a full page: open the next page or drop.
         if (need_next) begin
            if (cnt_rd + SUM_W'(commit_a) + SUM_W'(commit_b) < SUM_W'(PAGE_NUM)) begin
               next_open = 1'b1;
               state_n   = W_FILL;
               idx_n     = 8'd0;
            end else begin
               lost_n  = 1'b1;
               state_n = W_DROP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= W_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idx      <= '0;
         size_q   <= '0;
         page_sof <= 1'b0;
         lost_q   <= 1'b0;
         for (int i = 0; i < PAGE_NUM; i++) flags_q[i] <= '0;
      end else if (rx_clean_all) begin
         state    <= W_DROP;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idx      <= '0;
         lost_q   <= 1'b0;
         for (int i = 0; i < PAGE_NUM; i++) flags_q[i] <= '0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         lost_q <= lost_n;
         if (start_ok || next_open) size_q <= pkt_size;
         page_sof <= next_open ? 1'b0 : (start_ok ? 1'b1 : page_sof);
         if (commit_a) flags_q[wr_ptr] <= flags_a;
         if (commit_b) flags_q[wr_ptr + PAGE_W'(commit_a)] <= flags_b;
         wr_ptr <= wr_ptr + PAGE_W'(commit_a) + PAGE_W'(commit_b);
         rd_ptr <= rd_ptr + PAGE_W'(rd_ok);
         count  <= count + CNT_W'(commit_a) + CNT_W'(commit_b) - CNT_W'(rd_ok);
      end
   end

   assign ram_wr_en       = wr_en_c && !rx_clean_all;
   assign ram_wr_addr     = {wr_pg, wr_idx};
   assign ram_wr_data     = wr_data;
   assign ram_rd_addr     = {rd_ptr, rx_ram_rd_addr};
   assign rx_ram_rd_byte  = ram_rd_data;
   assign rx_ram_rd_flags = (count != '0) ? flags_q[rd_ptr] : 16'h0000;
   assign rx_ram_lost     = lost_q;
   assign rx_pending      = (count != '0);

endmodule

// File: tb/tb_cam_rx_page_mgr.sv
// tb_cam_rx_page_mgr
//    Bench for cam_rx_page_mgr: drives directed and random camera traffic,
//    keeps a page-ring reference model, and checks RAM writes, lost pulses,
//    head-page flags, pending and read-back bytes.

module tb_cam_rx_page_mgr;

   localparam int PAGE_W = 2;
   localparam int N      = 1 << PAGE_W;
   localparam int M_IDLE = 0;
   localparam int M_FILL = 1;
   localparam int M_DROP = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [7:0]          pkt_size;
   logic                wr_valid, wr_sof, wr_eof;
   logic [7:0]          wr_data;
   logic                ram_wr_en;
   logic [PAGE_W+7:0]   ram_wr_addr, ram_rd_addr;
   logic [7:0]          ram_wr_data, ram_rd_data;
   logic [7:0]          rx_ram_rd_addr;
   logic                rx_ram_rd_done, rx_clean_all;
   logic [7:0]          rx_ram_rd_byte;
   logic [15:0]         rx_ram_rd_flags;
   logic                rx_ram_lost, rx_pending;

   int vectors    = 0;
   int miscompares = 0;
   int lost_seen  = 0;

   cam_rx_page_mgr #(.PAGE_W(PAGE_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pkt_size        (pkt_size),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_sof          (wr_sof),
      .wr_eof          (wr_eof),
      .ram_wr_en       (ram_wr_en),
      .ram_wr_addr     (ram_wr_addr),
      .ram_wr_data     (ram_wr_data),
      .ram_rd_addr     (ram_rd_addr),
      .ram_rd_data     (ram_rd_data),
      .rx_ram_rd_addr  (rx_ram_rd_addr),
      .rx_ram_rd_done  (rx_ram_rd_done),
      .rx_clean_all    (rx_clean_all),
      .rx_ram_rd_byte  (rx_ram_rd_byte),
      .rx_ram_rd_flags (rx_ram_rd_flags),
      .rx_ram_lost     (rx_ram_lost),
      .rx_pending      (rx_pending)
   );

   always #5 clk = ~clk;

   // External 1R1W RAM with one clock of read latency.
   logic [7:0] ram [N*256];
   always @(posedge clk) begin
      if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= ram[ram_rd_addr];
   end

   // ---------------- reference model ----------------
   logic [15:0]        ring_q[$];
   logic [PAGE_W+15:0] exp_wr[$];
   logic [7:0]         mem_m [N][256];
   int exp_lost;
   int m_wr_ptr, m_rd_ptr, m_mode, m_len, m_size, m_page, m_fseq, m_seqcnt;
   bit m_psof;

   task automatic model_reset();
      ring_q.delete();
      exp_wr.delete();
      exp_lost = 0;
      m_wr_ptr = 0; m_rd_ptr = 0; m_mode = M_IDLE;
      m_len = 0; m_size = 0; m_page = 0; m_fseq = 0; m_seqcnt = 0; m_psof = 0;
   endtask

   task automatic model_commit(input bit eof);
      logic [5:0] sq;
`ifdef CAM_RX_FRAME_SEQ_EN
      sq = 6'(m_fseq);
`else
      sq = 6'd0;
`endif
      ring_q.push_back({8'(m_len - 1), m_psof, eof, sq});
      m_wr_ptr = (m_wr_ptr + 1) % N;
   endtask

   task automatic model_write(input logic [7:0] d, input bit eof);
      exp_wr.push_back({PAGE_W'(m_page), 8'(m_len), d});
      mem_m[m_page][m_len] = d;
      m_len++;
      m_mode = M_FILL;
      if (eof) begin
         model_commit(1'b1);
         m_mode = M_IDLE;
      end else if (m_len == m_size + 1) begin
         model_commit(1'b0);
         if (ring_q.size() < N) begin
            m_page = m_wr_ptr; m_len = 0; m_size = int'(pkt_size); m_psof = 0;
         end else begin
            exp_lost++;
            m_mode = M_DROP;
         end
      end
   endtask

   task automatic model_start(input logic [7:0] d, input bit eof);
      if (ring_q.size() < N) begin
         m_page = m_wr_ptr; m_len = 0; m_size = int'(pkt_size); m_psof = 1;
         m_fseq = m_seqcnt; m_seqcnt = (m_seqcnt + 1) % 64;
         model_write(d, eof);
      end else begin
         exp_lost++;
         m_mode = eof ? M_IDLE : M_DROP;
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit s,
                             input bit e, input bit rd, input bit cl);
      if (cl) begin
         ring_q.delete();
         m_wr_ptr = 0; m_rd_ptr = 0; m_mode = M_DROP;
         return;
      end
      if (rd && ring_q.size() > 0) begin
         void'(ring_q.pop_front());
         m_rd_ptr = (m_rd_ptr + 1) % N;
      end
      if (!v) return;
      if (m_mode == M_FILL) begin
         if (s) begin
            if (m_len > 0) model_commit(1'b0);
            model_start(d, e);
         end else begin
            model_write(d, e);
         end
      end else if (s) begin
         model_start(d, e);
      end else if (m_mode == M_DROP && e) begin
         m_mode = M_IDLE;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         if (ram_wr_en) begin
            vectors++;
            if (exp_wr.size() == 0) begin
               miscompares++;
               $display("FAIL ram_write: got addr %0h data %0h, required no write",
                        ram_wr_addr, ram_wr_data);
            end else begin
               logic [PAGE_W+15:0] e;
               e = exp_wr.pop_front();
               if ({ram_wr_addr, ram_wr_data} !== e) begin
                  miscompares++;
                  $display("FAIL ram_write: got addr %0h data %0h, required addr %0h data %0h",
                           ram_wr_addr, ram_wr_data, e[PAGE_W+15:8], e[7:0]);
               end
            end
         end
         if (rx_ram_lost) begin
            lost_seen++;
            vectors++;
            if (exp_lost == 0) begin
               miscompares++;
               $display("FAIL lost_pulse: got pulse, required none");
            end else begin
               exp_lost--;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input bit s, input bit e,
                      input bit rd, input bit cl);
      wr_valid = v; wr_data = d; wr_sof = s; wr_eof = e;
      rx_ram_rd_done = rd; rx_clean_all = cl;
      model_step(v, d, s, e, rd, cl);
      @(posedge clk); #1;
      wr_valid = 0; wr_sof = 0; wr_eof = 0; rx_ram_rd_done = 0; rx_clean_all = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_n = 0;
      wr_valid = 0; wr_data = 0; wr_sof = 0; wr_eof = 0;
      rx_ram_rd_done = 0; rx_clean_all = 0; rx_ram_rd_addr = 0; pkt_size = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk); #1;
   endtask

   // Checks head flags, pending and a few bytes; optionally frees the page.
   task automatic check_head(input bit do_free, input int nbytes);
      logic [15:0] hf;
      idle(2);
      chk("rx_pending", 32'(rx_pending), 32'(ring_q.size() != 0));
      hf = (ring_q.size() != 0) ? ring_q[0] : 16'h0000;
      chk("rx_ram_rd_flags", 32'(rx_ram_rd_flags), 32'(hf));
      if (ring_q.size() != 0) begin
         for (int k = 0; k < nbytes; k++) begin
            int i;
            i = (k == 0) ? int'(hf[15:8]) : int'($urandom_range(0, int'(hf[15:8])));
            rx_ram_rd_addr = 8'(i);
            idle(2);
            chk("rx_ram_rd_byte", 32'(rx_ram_rd_byte), 32'(mem_m[m_rd_ptr][i]));
         end
         if (do_free) cyc(0, 8'h00, 0, 0, 1, 0);
      end
   endtask

   task automatic send_frame(input int len, input int rd_at, input bit rnd);
      for (int i = 0; i < len; i++) begin
         bit s, rd;
         s  = (i == 0) || (rnd && $urandom_range(0, 14) == 0);
         rd = (i == rd_at) || (rnd && $urandom_range(0, 4) == 0);
         cyc(1, 8'($urandom), s, i == len - 1, rd, 0);
         if (rnd && $urandom_range(0, 5) == 0) idle(1);
      end
   endtask

   task automatic drain_check(input string name);
      idle(2);
      chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
      chk({name, "_lost_left"}, 32'(exp_lost), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int l0;
      logic [15:0] f1 [3];
      f1[0] = 16'h0980; f1[1] = 16'h0900; f1[2] = 16'h0440;
      do_reset();
      chk("reset_wr_en",   32'(ram_wr_en), 32'd0);
      chk("reset_lost",    32'(rx_ram_lost), 32'd0);
      chk("reset_pending", 32'(rx_pending), 32'd0);
      chk("reset_flags",   32'(rx_ram_rd_flags), 32'd0);

      // 25-byte frame in 10-byte pages
      pkt_size = 8'd9;
      l0 = lost_seen;
      send_frame(25, -1, 0);
      idle(2);
      chk("t1_pending", 32'(rx_pending), 32'd1);
      for (int p = 0; p < 3; p++) begin
         idle(1);
         chk("t1_flags_const", 32'(rx_ram_rd_flags), 32'(f1[p]));
         check_head(1, 2);
      end
      chk("t1_lost", 32'(lost_seen - l0), 32'd0);
      drain_check("t1");

      // 5 frames into a 4-page ring, no reads
      cyc(0, 0, 0, 0, 0, 1);
      pkt_size = 8'd3;
      l0 = lost_seen;
      for (int f = 0; f < 5; f++) send_frame(4, -1, 0);
      idle(2);
      chk("t2_lost", 32'(lost_seen - l0), 32'd1);
      chk("t2_pending", 32'(rx_pending), 32'd1);
      drain_check("t2");

      // full ring, rd_done on the sof clock frees a page for this frame
      l0 = lost_seen;
      send_frame(4, 0, 0);
      idle(2);
      chk("t3_lost", 32'(lost_seen - l0), 32'd0);
      for (int p = 0; p < 4; p++) check_head(1, 1);
      check_head(0, 0);
      drain_check("t3");

      // rd_done on empty ring; commit + rd_done in the same clock
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      check_head(0, 0);
      pkt_size = 8'd0;
      send_frame(1, -1, 0);
      send_frame(1, -1, 0);
      send_frame(1, 0, 0);
      for (int p = 0; p < 3; p++) check_head(1, 1);
      check_head(0, 0);
      drain_check("t4");

      // flush mid-page, rest of frame discarded, next frame at page 0
      pkt_size = 8'd20;
      for (int i = 0; i < 5; i++) cyc(1, 8'(i + 1), i == 0, 0, 0, 0);
      cyc(1, 8'h66, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, i == 3, 0, 0);
      check_head(0, 0);
      pkt_size = 8'd2;
      send_frame(3, -1, 0);
      check_head(1, 3);
      drain_check("t5");

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 9) == 0) pkt_size = 8'($urandom_range(0, 6));
         if (r < 60)      send_frame($urandom_range(1, 14), -1, 1);
         else if (r < 85) check_head(1, 2);
         else if (r < 95) check_head(0, 1);
         else             cyc(0, 0, 0, 0, 0, 1);
      end
      drain_check("rand");

      // frame sequence numbering over 65 frames
      do_reset();
      pkt_size = 8'd0;
      for (int f = 1; f <= 65; f++) begin
         send_frame(1, -1, 0);
         idle(2);
         if (f == 64 || f == 65) begin
`ifdef CAM_RX_FRAME_SEQ_EN
            chk("t6_seq", 32'(rx_ram_rd_flags[5:0]), (f == 64) ? 32'd63 : 32'd0);
`else
            chk("t6_seq", 32'(rx_ram_rd_flags[5:0]), 32'd0);
`endif
         end
         check_head(1, 0);
      end
      drain_check("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
